// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a WIDTH-bit JK flip-flop bank: masked SET/CLR/TOGGLE or N-step counting.
// Optional macro JK_SEQ_DOWN_EN: COUNT with latched mask[0]=1 counts down instead of up.
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COUNT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_SET, OP_CLR, OP_TOG, OP_CNT} op_t;

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] step;
  logic             down;
  logic [WIDTH-1:0] cnt_t;

`ifdef JK_SEQ_DOWN_EN
  assign down = mask_r[0];
`else
  assign down = 1'b0;
`endif

  // Ripple enable: bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic acc;
    acc   = 1'b1;
    cnt_t = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_t[i] = acc;
      acc      = acc & (down ? ~q[i] : q[i]);
    end
  end

  always_comb begin
    j_out = '0;
    k_out = '0;
    case (state)
      S_APPLY: begin
        case (op_r)
          OP_SET: j_out = mask_r;
          OP_CLR: k_out = mask_r;
          OP_TOG: begin
            j_out = mask_r;
            k_out = mask_r;
          end
          default: ;
        endcase
      end
      S_COUNT: begin
        j_out = cnt_t;
        k_out = cnt_t;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_r      <= OP_SET;
      mask_r    <= '0;
      step      <= '0;
      q         <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      q <= (j_out & ~q) | (~k_out & q);
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_r      <= op_t'(cmd_op);
            mask_r    <= cmd_mask;
            step      <= cmd_len;
            cmd_ready <= 1'b0;
            if (op_t'(cmd_op) != OP_CNT) begin
              state <= S_APPLY;
              busy  <= 1'b1;
            end else if (cmd_len != '0) begin
              state <= S_COUNT;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_APPLY: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_COUNT: begin
          step <= step - CNT_W'(1);
          if (step == CNT_W'(1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed and random command checks for jk_bank_sequencer against an arithmetic bank model.
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_len;
  logic [3:0] j_out, k_out, q;
  logic       busy, done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [3:0]  mq    = '0;

  jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len),
    .j_out(j_out), .k_out(k_out), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge where the block is IDLE again.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] m, input logic [7:0] len,
                        input bit poke);
    logic [3:0] nq, ej, ek;
    bit dn;
    chk1("ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_mask = 4'($urandom); cmd_len = 8'($urandom);
    chk1("ready_busy", cmd_ready, 1'b0);
    if (op != 2'd3) begin
      case (op)
        2'd0:    begin nq = mq | m;  ej = m;    ek = 4'h0; end
        2'd1:    begin nq = mq & ~m; ej = 4'h0; ek = m;    end
        default: begin nq = mq ^ m;  ej = m;    ek = m;    end
      endcase
      chk1("apply_busy", busy, 1'b1);
      chk1("apply_done", done, 1'b0);
      chk4("apply_j", j_out, ej);
      chk4("apply_k", k_out, ek);
      chk4("apply_q_hold", q, mq);
      @(negedge clk);
      mq = nq;
    end else if (len != 8'd0) begin
`ifdef JK_SEQ_DOWN_EN
      dn = m[0];
`else
      dn = 1'b0;
`endif
      for (int i = 0; i < int'(len); i++) begin
        nq = dn ? mq - 4'd1 : mq + 4'd1;
        chk1("cnt_busy", busy, 1'b1);
        chk1("cnt_done", done, 1'b0);
        chk4("cnt_q", q, mq);
        chk4("cnt_j", j_out, mq ^ nq);
        chk4("cnt_k", k_out, mq ^ nq);
        if (poke && i == 1) begin
          cmd_valid = 1'b1; cmd_op = 2'd2; cmd_mask = 4'hF;
        end else begin
          cmd_valid = 1'b0;
        end
        @(negedge clk);
        mq = nq;
      end
      cmd_valid = 1'b0;
    end
    chk1("done_pulse", done, 1'b1);
    chk1("done_busy", busy, 1'b0);
    chk4("done_q", q, mq);
    chk4("done_j", j_out, 4'h0);
    chk4("done_k", k_out, 4'h0);
    @(negedge clk);
    chk1("post_done", done, 1'b0);
    chk1("post_ready", cmd_ready, 1'b1);
    chk4("post_q", q, mq);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_mask = 4'hF; cmd_len = 8'd0;
    repeat (3) @(negedge clk);
    chk4("rst_q", q, 4'h0);
    chk1("rst_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk4("rst_j", j_out, 4'h0);
    chk4("rst_k", k_out, 4'h0);
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk4("rst_release_q", q, 4'h0);
    chk1("rst_release_busy", busy, 1'b0);

    do_cmd(2'd0, 4'b0101, 8'd0, 1'b0);
    chk4("set_0101", q, 4'b0101);
    do_cmd(2'd2, 4'b1111, 8'd0, 1'b0);
    chk4("tog_1010", q, 4'b1010);
    do_cmd(2'd1, 4'b1000, 8'd0, 1'b0);
    chk4("clr_0010", q, 4'b0010);
    do_cmd(2'd3, 4'b0000, 8'd3, 1'b0);
    chk4("cnt3_0101", q, 4'b0101);
    do_cmd(2'd1, 4'b1111, 8'd0, 1'b0);
    do_cmd(2'd0, 4'b1110, 8'd0, 1'b0);
    do_cmd(2'd3, 4'b0000, 8'd3, 1'b0);
    chk4("cnt_wrap_0001", q, 4'b0001);
    do_cmd(2'd3, 4'b0000, 8'd0, 1'b0);
    chk4("cnt0_hold", q, 4'b0001);
    do_cmd(2'd3, 4'b0000, 8'd5, 1'b1);
    chk4("poke_ignored", q, 4'b0110);

    // Reset in the middle of a long count.
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_mask = 4'h0; cmd_len = 8'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk4("abort_pre_q", q, mq);
      @(negedge clk);
      mq = mq + 4'd1;
    end
    reset = 1'b1;
    #1;
    mq = 4'h0;
    chk4("abort_q", q, 4'h0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", cmd_ready, 1'b1);
    chk1("abort_done", done, 1'b0);
    chk4("abort_j", j_out, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("abort_no_done", done, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk1("abort_idle_done", done, 1'b0);
    chk4("abort_idle_q", q, 4'h0);

    do_cmd(2'd0, 4'b0001, 8'd0, 1'b0);
    do_cmd(2'd3, 4'b0001, 8'd2, 1'b0);
`ifdef JK_SEQ_DOWN_EN
    chk4("dir_cnt", q, 4'b1111);
`else
    chk4("dir_cnt", q, 4'b0011);
`endif

    for (int n = 0; n < 30; n++) begin
      logic [1:0] rop;
      logic [3:0] rm;
      logic [7:0] rl;
      rop = 2'($urandom);
      rm  = 4'($urandom);
      rl  = 8'($urandom_range(6, 0));
      do_cmd(rop, rm, rl, (rop == 2'd3 && rl >= 8'd3) ? 1'($urandom) : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
